// File: rtl/fir_mac_sequencer.sv
// Control sequencer for the serial-I/O FIR filter: buffers one sample,
// issues its tap cycles to the shared MAC lanes and holds the lane-sum result.
`timescale 1ns/1ps
module fir_mac_sequencer #(
  parameter int DATA_WIDTH    = 24,
  parameter int FIR_DEPTH     = 256,
  parameter int PIPELINES     = 8,
  parameter int MAC_LATENCY   = 3,
  parameter int ADDER_LATENCY = 3,
  localparam int TPL = FIR_DEPTH / PIPELINES,
  localparam int AW  = $clog2(FIR_DEPTH),
  localparam int TW  = (TPL > 1) ? $clog2(TPL) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_sample_valid,
  output logic          o_ready,
  output logic          o_sample_ack,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [AW-1:0] o_newest_ptr,
  output logic [TW-1:0] o_tap_idx,
  output logic          o_mac_valid,
  output logic          o_mac_first,
  output logic          o_mac_last,
  output logic          o_pipe_en,
  output logic          o_result_valid,
  input  logic          i_result_ready,
  output logic          o_primed
);

  localparam int DL = MAC_LATENCY + ADDER_LATENCY;
  localparam int DW = (DL > 1) ? $clog2(DL) : 1;
  localparam int PW = AW + 1;

  localparam logic [TW-1:0] TAP_LAST   = TW'(TPL - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DL - 1);
  localparam logic [PW-1:0] PRIME_FULL = PW'(FIR_DEPTH);

  if (DATA_WIDTH < 1 || FIR_DEPTH < 2 ||
      (FIR_DEPTH & (FIR_DEPTH - 1)) != 0 ||
      (PIPELINES & (PIPELINES - 1)) != 0 ||
      FIR_DEPTH % PIPELINES != 0 || DL < 1) begin : g_bad_cfg
    $error("fir_mac_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    COMPUTE,
    DRAIN,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] newest_q;
  logic [TW-1:0] tap_q, tap_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [PW-1:0] prime_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      drain_q <= drain_d;
    end
  end

  // Pointers advance on the edge that leaves WRITE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      newest_q <= '0;
      prime_q  <= '0;
    end else if (state_q == WRITE) begin
      newest_q <= wr_ptr_q;
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (prime_q != PRIME_FULL)
        prime_q <= prime_q + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    tap_d          = tap_q;
    drain_d        = drain_q;
    o_ready        = 1'b0;
    o_sample_ack   = 1'b0;
    o_wr_en        = 1'b0;
    o_mac_valid    = 1'b0;
    o_mac_first    = 1'b0;
    o_mac_last     = 1'b0;
    o_result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_en && i_sample_valid)
          state_d = WRITE;
      end
      WRITE: begin
        o_sample_ack = 1'b1;
        o_wr_en      = 1'b1;
        tap_d        = '0;
        state_d      = COMPUTE;
      end
      COMPUTE: begin
        if (i_en) begin
          o_mac_valid = 1'b1;
          o_mac_first = (tap_q == '0);
          o_mac_last  = (tap_q == TAP_LAST);
          tap_d       = tap_q + 1'b1;
          if (tap_q == TAP_LAST) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (i_en) begin
          if (drain_q == DRAIN_LAST)
            state_d = HOLD;
          else
            drain_d = drain_q + 1'b1;
        end
      end
      HOLD: begin
        o_result_valid = 1'b1;
        if (i_result_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_wr_addr    = wr_ptr_q;
  assign o_newest_ptr = newest_q;
  assign o_tap_idx    = tap_q;
  assign o_pipe_en    = i_en;
  assign o_primed     = (prime_q == PRIME_FULL);

`ifndef SYNTHESIS
  a_hold_stable: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    o_result_valid && !i_result_ready |=> o_result_valid);

  a_ack_one_shot: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    o_sample_ack |=> !o_sample_ack);

  a_ack_from_idle: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    o_sample_ack |-> $past(o_ready));

  a_issue_gated: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    o_mac_valid |-> i_en);
`endif

endmodule
